// File: rtl/ptn_checker.sv
// Receive-side checker for the 8-bit incrementing test pattern: lock tracking and error counting.
// Optional stall detection is built when PTN_CHK_TIMEOUT_EN is defined.
module ptn_checker #(
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned UNLOCK_CNT  = 3,
    parameter int unsigned ERR_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 65536
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic [7:0]       i_ptn,
    input  logic             i_clr_err,
    output logic             o_lock,
    output logic             o_err_pulse,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_stall
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [7:0]       r_s;
    logic             s_vld;
    logic [7:0]       r_last, last_n;
    logic             r_ref_vld, ref_vld_n;
    logic [GW-1:0]    good_run, good_run_n;
    logic [BW-1:0]    bad_run, bad_run_n;
    logic             pulse_n;
    logic [ERR_W-1:0] cnt_n;
    logic             change;
    logic             good;

`ifdef PTN_CHK_TIMEOUT_EN
    logic [31:0]      idle_cnt, idle_n;
    logic             stall_n;
`endif

    // s_vld keeps the byte captured during reset from becoming the reference.
    assign change = s_vld && r_ref_vld && (r_s != r_last);
    assign good   = (r_s == r_last + 8'd1);
    assign o_lock = (state == LOCKED);

    always_comb begin
        state_n    = state;
        good_run_n = good_run;
        bad_run_n  = bad_run;
        last_n     = r_last;
        ref_vld_n  = r_ref_vld;
        pulse_n    = 1'b0;
        cnt_n      = o_err_cnt;
`ifdef PTN_CHK_TIMEOUT_EN
        idle_n     = idle_cnt;
        stall_n    = o_stall;
`endif

        if (s_vld && !r_ref_vld) begin
            last_n    = r_s;
            ref_vld_n = 1'b1;
        end

        if (change) begin
            last_n = r_s;
`ifdef PTN_CHK_TIMEOUT_EN
            idle_n  = '0;
            stall_n = 1'b0;
`endif
            case (state)
                HUNT: begin
                    if (good) begin
                        if (good_run == GW'(LOCK_CNT - 1)) begin
                            state_n    = LOCKED;
                            good_run_n = '0;
                        end else begin
                            good_run_n = good_run + GW'(1);
                        end
                    end else begin
                        good_run_n = '0;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        bad_run_n = '0;
                    end else begin
                        pulse_n = 1'b1;
                        if (!(&o_err_cnt)) begin
                            cnt_n = o_err_cnt + ERR_W'(1);
                        end
                        if (bad_run == BW'(UNLOCK_CNT - 1)) begin
                            state_n    = HUNT;
                            bad_run_n  = '0;
                            good_run_n = '0;
                        end else begin
                            bad_run_n = bad_run + BW'(1);
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
`ifdef PTN_CHK_TIMEOUT_EN
        else if (state == LOCKED) begin
            if (idle_cnt == TIMEOUT_CYC - 1) begin
                stall_n    = 1'b1;
                state_n    = HUNT;
                good_run_n = '0;
                bad_run_n  = '0;
                idle_n     = '0;
            end else begin
                idle_n = idle_cnt + 32'd1;
            end
        end else begin
            idle_n = '0;
        end
`endif

        // Clear wins over a same-cycle increment; the pulse is unaffected.
        if (i_clr_err) begin
            cnt_n = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state       <= HUNT;
            r_s         <= '0;
            s_vld       <= 1'b0;
            r_last      <= '0;
            r_ref_vld   <= 1'b0;
            good_run    <= '0;
            bad_run     <= '0;
            o_err_pulse <= 1'b0;
            o_err_cnt   <= '0;
        end else begin
            state       <= state_n;
            r_s         <= i_ptn;
            s_vld       <= 1'b1;
            r_last      <= last_n;
            r_ref_vld   <= ref_vld_n;
            good_run    <= good_run_n;
            bad_run     <= bad_run_n;
            o_err_pulse <= pulse_n;
            o_err_cnt   <= cnt_n;
        end
    end

`ifdef PTN_CHK_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            idle_cnt <= '0;
            o_stall  <= 1'b0;
        end else begin
            idle_cnt <= idle_n;
            o_stall  <= stall_n;
        end
    end
`else
    assign o_stall = 1'b0;
`endif

endmodule

// File: tb/tb_ptn_checker.sv
// Self-checking bench for ptn_checker: directed table, corner sequences, randomized run vs model.
module tb_ptn_checker;

    localparam int unsigned LOCK_CNT    = 4;
    localparam int unsigned UNLOCK_CNT  = 3;
    localparam int unsigned ERR_W       = 4;
    localparam int unsigned TIMEOUT_CYC = 100;
    localparam int          CNT_MAX     = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             res = 1'b1;
    logic [7:0]       ptn = 8'h00;
    logic             clr = 1'b0;
    logic             lock;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic             stall;

    int n_pass  = 0;
    int n_total = 0;

    ptn_checker #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT),
        .ERR_W      (ERR_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk      (clk),
        .i_res      (res),
        .i_ptn      (ptn),
        .i_clr_err  (clr),
        .o_lock     (lock),
        .o_err_pulse(err_pulse),
        .o_err_cnt  (err_cnt),
        .o_stall    (stall)
    );

    always #5 clk = ~clk;

    // Reference model: two-edge pipeline expressed as "sample seen last edge" plus lock bookkeeping.
    int m_s, m_svld, m_last, m_rvld, m_lock, m_gr, m_br, m_cnt, m_pulse, m_stall, m_idle;

    task automatic model_reset();
        m_s = 0; m_svld = 0; m_last = 0; m_rvld = 0; m_lock = 0;
        m_gr = 0; m_br = 0; m_cnt = 0; m_pulse = 0; m_stall = 0; m_idle = 0;
    endtask

    task automatic model_edge(input int p, input int c, input int r);
        if (r != 0) begin
            model_reset();
            return;
        end
        m_pulse = 0;
        if (m_svld != 0 && m_rvld == 0) begin
            m_last = m_s;
            m_rvld = 1;
        end else if (m_svld != 0 && m_s != m_last) begin
            int is_good;
            is_good = (m_s == ((m_last + 1) % 256)) ? 1 : 0;
            m_last  = m_s;
            m_stall = 0;
            m_idle  = 0;
            if (m_lock == 0) begin
                if (is_good != 0) begin
                    m_gr++;
                    if (m_gr == LOCK_CNT) begin
                        m_lock = 1;
                        m_gr   = 0;
                    end
                end else begin
                    m_gr = 0;
                end
            end else if (is_good != 0) begin
                m_br = 0;
            end else begin
                m_pulse = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
                m_br++;
                if (m_br == UNLOCK_CNT) begin
                    m_lock = 0;
                    m_br   = 0;
                    m_gr   = 0;
                end
            end
        end else begin
`ifdef PTN_CHK_TIMEOUT_EN
            if (m_lock != 0) begin
                m_idle++;
                if (m_idle == TIMEOUT_CYC) begin
                    m_stall = 1;
                    m_lock  = 0;
                    m_gr    = 0;
                    m_br    = 0;
                    m_idle  = 0;
                end
            end else begin
                m_idle = 0;
            end
`endif
        end
        if (c != 0) m_cnt = 0;
        m_s    = p;
        m_svld = 1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cycle(input logic [7:0] p, input logic c, input logic r);
        @(negedge clk);
        ptn = p;
        clr = c;
        res = r;
        @(posedge clk);
        model_edge(int'(p), int'(c), int'(r));
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_lock"},  int'(lock),      m_lock);
        chk({tag, "_pulse"}, int'(err_pulse), m_pulse);
        chk({tag, "_cnt"},   int'(err_cnt),   m_cnt);
        chk({tag, "_stall"}, int'(stall),     m_stall);
    endtask

    task automatic step(input logic [7:0] p, input logic c, input string tag);
        cycle(p, c, 1'b0);
        check_model(tag);
    endtask

    typedef struct {
        logic [7:0] p;
        logic       c;
        logic       r;
        logic       lock;
        logic       pulse;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [7:0] v;
        model_reset();

        // Pattern changing every cycle through the wrap, then errors and unlock.
        tbl[0]  = '{8'hFC, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[4]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[6]  = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[7]  = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[8]  = '{8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[9]  = '{8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1};
        tbl[10] = '{8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[11] = '{8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[12] = '{8'h20, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2};
        tbl[13] = '{8'h30, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3};
        tbl[14] = '{8'h30, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4};
        tbl[15] = '{8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].p, tbl[i].c, tbl[i].r);
            chk($sformatf("tbl%0d_lock", i),  int'(lock),      int'(tbl[i].lock));
            chk($sformatf("tbl%0d_pulse", i), int'(err_pulse), int'(tbl[i].pulse));
            chk($sformatf("tbl%0d_cnt", i),   int'(err_cnt),   int'(tbl[i].cnt));
            chk($sformatf("tbl%0d_stall", i), int'(stall),     0);
        end

        // Relock with the pattern advancing every 4 cycles.
        for (int k = 1; k <= 4; k++)
            for (int j = 0; j < 4; j++) step(8'h30 + 8'(k), 1'b0, "relock");
        chk("relock_lock", int'(lock), 1);
        chk("relock_cnt",  int'(err_cnt), 0);

        // Single skip 0x10->0x12, then 0x13 recovers.
        step(8'h10, 1'b0, "skip"); step(8'h10, 1'b0, "skip");
        step(8'h12, 1'b0, "skip"); step(8'h13, 1'b0, "skip");
        chk("skip_pulse", int'(err_pulse), 1);
        chk("skip_cnt",   int'(err_cnt),   2);
        step(8'h14, 1'b0, "skip");
        chk("skip_lock", int'(lock), 1);

        // Saturation: bad,bad,good repeated keeps lock while accumulating errors.
        v = 8'h14;
        for (int k = 0; k < 10; k++) begin
            v = v + 8'd2; step(v, 1'b0, "sat");
            v = v + 8'd2; step(v, 1'b0, "sat");
            v = v + 8'd1; step(v, 1'b0, "sat");
        end
        step(v, 1'b0, "sat"); step(v, 1'b0, "sat");
        chk("sat_cnt",  int'(err_cnt), CNT_MAX);
        chk("sat_lock", int'(lock), 1);

        // Clear coincident with a bad transition being evaluated.
        v = v + 8'd5;
        step(v, 1'b0, "clr");
        step(v, 1'b1, "clr");
        chk("clr_cnt",   int'(err_cnt),   0);
        chk("clr_pulse", int'(err_pulse), 1);

        // Constant input while locked.
`ifdef PTN_CHK_TIMEOUT_EN
        for (int k = 0; k < TIMEOUT_CYC + 5; k++) step(v, 1'b0, "idle");
        chk("idle_stall", int'(stall), 1);
        chk("idle_lock",  int'(lock),  0);
        step(v + 8'd1, 1'b0, "idle"); step(v + 8'd1, 1'b0, "idle");
        chk("idle_stall_clr", int'(stall), 0);
`else
        for (int k = 0; k < 1000; k++) step(v, 1'b0, "idle");
        chk("idle_stall", int'(stall), 0);
        chk("idle_lock",  int'(lock),  1);
`endif

        // Reset while locked with five errors, last value 0x33.
        cycle(8'h20, 1'b0, 1'b1);
        for (int k = 0; k < 15; k++) begin
            logic [7:0] seq [15];
            seq = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h26, 8'h28, 8'h29,
                    8'h2B, 8'h2D, 8'h2E, 8'h30, 8'h31, 8'h32, 8'h33};
            step(seq[k], 1'b0, "pre_rst"); step(seq[k], 1'b0, "pre_rst");
        end
        step(8'h33, 1'b0, "pre_rst"); step(8'h33, 1'b0, "pre_rst");
        chk("pre_rst_cnt",  int'(err_cnt), 5);
        chk("pre_rst_lock", int'(lock), 1);
        cycle(8'h80, 1'b0, 1'b1);
        chk("rst_lock",  int'(lock),      0);
        chk("rst_pulse", int'(err_pulse), 0);
        chk("rst_cnt",   int'(err_cnt),   0);
        chk("rst_stall", int'(stall),     0);
        for (int k = 0; k < 5; k++) begin
            step(8'h80, 1'b0, "post_rst");
            chk("post_rst_pulse", int'(err_pulse), 0);
        end

        // Randomized traffic against the model.
        v = 8'h80;
        for (int k = 0; k < 3000; k++) begin
            int unsigned r;
            logic c, rs;
            r = $urandom_range(0, 99);
            if (r < 60)      v = v + 8'd1;
            else if (r < 75) v = v;
            else if (r < 90) v = 8'($urandom_range(0, 255));
            else             v = v + 8'd2;
            c  = ($urandom_range(0, 49) == 0);
            rs = ($urandom_range(0, 499) == 0);
            cycle(v, c, rs);
            check_model("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
